eth_ingress_buf: RTL

Per-port store-and-forward ingress buffer that sits directly upstream of one input port of the two-port switch `eth_sw`, feeding its `inData*`/`inSop*`/`inEop*` and obeying its `port*Stall`. It accepts 32-bit sop/eop-framed packets from the MAC side, which cannot be back-pressured. It forwards only complete packets, each as one contiguous burst. Packets that overflow the buffer or are framed incorrectly are dropped whole and counted.

---
 rtl/eth_ingress_buf_if.sv | 28 ++
 rtl/eth_ingress_buf.sv | 118 +++++++++++
 2 files changed

// File: rtl/eth_ingress_buf_if.sv
// MAC-side input stream, switch-side output stream and status counters of one ingress buffer.
// The buffer uses the slave modport; the MAC/switch environment uses the master modport.
interface eth_ingress_buf_if #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] inData;
   logic              inSop;
   logic              inEop;
   logic              portStall;
   logic [DATA_W-1:0] outData;
   logic              outSop;
   logic              outEop;
   logic [CNT_W-1:0]  pktCount;
   logic [15:0]       dropCount;

   modport master (
      output inData, inSop, inEop, portStall,
      input  outData, outSop, outEop, pktCount, dropCount
   );

   modport slave (
      input  inData, inSop, inEop, portStall,
      output outData, outSop, outEop, pktCount, dropCount
   );
endinterface

// File: rtl/eth_ingress_buf.sv
// Store-and-forward ingress buffer: holds whole packets from a MAC that cannot be stalled
// and releases each complete packet to the switch port as one contiguous burst.
module eth_ingress_buf #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              resetN,
   eth_ingress_buf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wr_state_t;
   typedef enum logic       {R_IDLE, R_SEND}            rd_state_t;

   logic [DATA_W:0]   mem [DEPTH];
   logic [PW-1:0]     wr_ptr, cm_ptr, rd_ptr;
   wr_state_t         wr_state;
   rd_state_t         rd_state;
   logic [DATA_W-1:0] out_data;
   logic              out_sop, out_eop;
   logic [PW-1:0]     pkt_count;
   logic [15:0]       drop_count;

   // Write-side decisions. A sop arriving mid-packet first rolls the partial packet back,
   // so the new packet is sized against the space left after that rollback.
   logic          abort, word_in, full, overflow, wr_en, commit;
   logic [PW-1:0] base, used;
   logic [1:0]    drop_inc;
   logic [16:0]   drop_sum;

   assign abort    = (wr_state == W_RECV) && bus.inSop;
   assign base     = abort ? cm_ptr : wr_ptr;
   assign used     = base - rd_ptr;
   assign full     = (used == PW'(DEPTH));
   assign word_in  = bus.inSop || (wr_state == W_RECV);
   assign overflow = word_in && full;
   assign wr_en    = word_in && !full;
   assign commit   = wr_en && bus.inEop;
   assign drop_inc = 2'(abort) + 2'(overflow);
   assign drop_sum = {1'b0, drop_count} + 17'(drop_inc);

   // Read-side decisions.
   logic          start, emit, pop_eop;
   logic [DATA_W:0] rd_word;

   assign rd_word = mem[rd_ptr[AW-1:0]];
   assign start   = (rd_state == R_IDLE) && (pkt_count != '0) && !bus.portStall;
   assign emit    = start || (rd_state == R_SEND);
   assign pop_eop = emit && rd_word[DATA_W];

   // NOTE: the packet store carries no reset; pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[base[AW-1:0]] <= {bus.inEop, bus.inData};
   end

   // NOTE: all state below uses non-blocking assignments so every decision sees pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         wr_state <= W_IDLE;
         wr_ptr   <= '0;
         cm_ptr   <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr   <= base + PW'(1);
            wr_state <= bus.inEop ? W_IDLE : W_RECV;
         end else if (overflow) begin
            wr_ptr   <= cm_ptr;
            wr_state <= bus.inEop ? W_IDLE : W_DISCARD;
         end else if (wr_state == W_DISCARD && bus.inEop) begin
            wr_state <= W_IDLE;
         end
         if (commit) cm_ptr <= base + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rd_state <= R_IDLE;
         rd_ptr   <= '0;
         out_data <= '0;
         out_sop  <= 1'b0;
         out_eop  <= 1'b0;
      end else if (emit) begin
         rd_ptr   <= rd_ptr + PW'(1);
         out_data <= rd_word[DATA_W-1:0];
         out_sop  <= start;
         out_eop  <= rd_word[DATA_W];
         rd_state <= rd_word[DATA_W] ? R_IDLE : R_SEND;
      end else begin
         out_data <= '0;
         out_sop  <= 1'b0;
         out_eop  <= 1'b0;
      end
   end

   // A commit and a final-word emission on the same edge cancel out.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         unique case ({commit, pop_eop})
            2'b10:   pkt_count <= pkt_count + PW'(1);
            2'b01:   pkt_count <= pkt_count - PW'(1);
            default: ;
         endcase
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   assign bus.outData   = out_data;
   assign bus.outSop    = out_sop;
   assign bus.outEop    = out_eop;
   assign bus.pktCount  = pkt_count;
   assign bus.dropCount = drop_count;
endmodule
